ps2_keyboard_tx: RTL



---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_tx_fifo.sv | 62 ++++++
 rtl/ps2_keyboard_tx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 transmitter types, constants and frame helpers.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS   = 11;
    localparam int unsigned PS2_CODE_W       = 8;
    localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BIT_HI,
        S_BIT_LO,
        S_GAP
    } ps2_state_t;

    // FIFO entry when release-code expansion is enabled
    typedef struct packed {
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

    function automatic logic ps2_parity(input logic [7:0] code);
        return ~^code;
    endfunction

    // Frame bits in transmit order: bit 0 = start, bit 10 = stop
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] code);
        return {1'b1, ps2_parity(code), code, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous scan-code FIFO with registered full/empty flags and occupancy count.
module ps2_tx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned WIDTH = PS2_CODE_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (push_ok && !pop_ok) begin
            count_d = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // Storage carries no reset; pointers alone define the contents
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard transmitter: buffers scan codes and drives 11-bit frames on ps2_clk/ps2_data.
// Define PS2_TX_BREAK_EN to expand entries flagged in_break into an F0 prefix frame plus the code frame.
module ps2_keyboard_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAP_CYCLES = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_code,
    input  logic       in_break,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       tx_done
);
    localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(PS2_FRAME_BITS);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
`ifdef PS2_TX_BREAK_EN
    localparam int unsigned ENTRY_W = $bits(ps2_entry_t);
`else
    localparam int unsigned ENTRY_W = PS2_CODE_W;
`endif

    ps2_state_t                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
    logic                      clk_d, data_d, done_d, busy_d;
    logic [7:0]                code_sel;

    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               push;
    logic               pop;

`ifdef PS2_TX_BREAK_EN
    logic       pend_q, pend_d;
    logic [7:0] pend_code_q, pend_code_d;
    ps2_entry_t head;

    assign fifo_wdata = ENTRY_W'({in_break, in_code});
    assign head       = ps2_entry_t'(fifo_rdata);
`else
    logic pend_q, pend_d;
    logic unused_break;

    assign fifo_wdata   = in_code;
    assign pend_q       = 1'b0;
    assign pend_d       = 1'b0;
    assign unused_break = in_break;
`endif

    assign push     = in_valid && !fifo_full;
    assign in_ready = !fifo_full;

    ps2_tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (fifo_wdata),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Next-state and next-output logic; line levels are registered below
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        clk_d    = ps2_clk;
        data_d   = ps2_data;
        done_d   = 1'b0;
        pop      = 1'b0;
        code_sel = fifo_rdata[7:0];
`ifdef PS2_TX_BREAK_EN
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pend_q || !fifo_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
`ifdef PS2_TX_BREAK_EN
                if (pend_q) begin
                    code_sel = pend_code_q;
                    pend_d   = 1'b0;
                end else begin
                    pop = 1'b1;
                    if (head.brk) begin
                        code_sel    = PS2_BREAK_PREFIX;
                        pend_d      = 1'b1;
                        pend_code_d = head.code;
                    end
                end
`else
                pop = 1'b1;
`endif
                frame_d = ps2_frame(code_sel);
                data_d  = frame_d[0];
                clk_d   = 1'b1;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = S_BIT_HI;
            end
            S_BIT_HI: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    state_d = S_BIT_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BIT_LO: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    clk_d = 1'b1;
                    if (bit_q == BIT_W'(PS2_FRAME_BITS - 1)) begin
                        data_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_GAP;
                    end else begin
                        // Data moves only as the clock rises, never inside a low phase
                        bit_d   = bit_q + BIT_W'(1);
                        data_d  = frame_q[bit_d];
                        state_d = S_BIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) || pend_d || push
              || (fifo_count > CW'(1))
              || ((fifo_count == CW'(1)) && !pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            tx_done  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            ps2_clk  <= clk_d;
            ps2_data <= data_d;
            tx_done  <= done_d;
            busy     <= busy_d;
        end
    end

`ifdef PS2_TX_BREAK_EN
    // Pending release code waiting behind its F0 prefix frame
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q      <= 1'b0;
            pend_code_q <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
        end
    end
`endif

endmodule
